// File: rtl/ascon_pkg.sv
// Shared Ascon types: operating modes, stream packet types, padder states
// and the per-mode rate lookup.
package ascon_pkg;

    typedef enum logic [1:0] {
        MODE_AEAD128 = 2'd0,
        MODE_HASH256 = 2'd1,
        MODE_XOF128  = 2'd2,
        MODE_CXOF128 = 2'd3
    } ascon_mode_t;

    typedef enum logic [2:0] {
        TU_KEY   = 3'd0,
        TU_NONCE = 3'd1,
        TU_AD    = 3'd2,
        TU_PT    = 3'd3,
        TU_CT    = 3'd4,
        TU_TAG   = 3'd5,
        TU_MSG   = 3'd6,
        TU_Z     = 3'd7
    } axi_tuser_t;

    typedef enum logic [1:0] {
        PASS      = 2'd0,
        PAD_ONE   = 2'd1,
        ZERO_FILL = 2'd2
    } padder_state_t;

    localparam logic [7:0] ASCON_PAD_BYTE = 8'h01;

    function automatic int ascon_rate_bytes(ascon_mode_t mode);
        return (mode == MODE_AEAD128) ? 16 : 8;
    endfunction

    // Packet types that carry message material and therefore get padded.
    function automatic logic ascon_is_padded(axi_tuser_t u);
        return (u == TU_AD) || (u == TU_PT) || (u == TU_MSG) || (u == TU_Z);
    endfunction

endpackage

// File: rtl/ascon_pad_mask.sv
// Combinational final-beat masker: keeps the k valid low bytes, inserts the
// 0x01 pad byte at position k and zeroes everything above it.
// With ASCON_PADDER_TKEEP_CHECK_EN, k is the lowest zero bit of tkeep; otherwise popcount.
module ascon_pad_mask
    import ascon_pkg::*;
#(
    parameter int BUS_BYTES = 8,
    localparam int KW = $clog2(BUS_BYTES + 1)
) (
    input  logic [8*BUS_BYTES-1:0] tdata_i,
    input  logic [BUS_BYTES-1:0]   tkeep_i,
    output logic [8*BUS_BYTES-1:0] data_o,
    output logic [KW-1:0]          k_o,
    output logic                   full_o,
    output logic                   contig_o
);

    always_comb begin
        k_o = '0;
`ifdef ASCON_PADDER_TKEEP_CHECK_EN
        k_o = KW'(BUS_BYTES);
        for (int i = BUS_BYTES - 1; i >= 0; i--) begin
            if (!tkeep_i[i]) k_o = KW'(i);
        end
`else
        for (int i = 0; i < BUS_BYTES; i++) begin
            k_o = k_o + KW'(tkeep_i[i]);
        end
`endif
    end

    always_comb begin
        data_o = '0;
        for (int i = 0; i < BUS_BYTES; i++) begin
            if (i < int'(k_o))
                data_o[8*i +: 8] = tdata_i[8*i +: 8];
            else if (i == int'(k_o))
                data_o[8*i +: 8] = ASCON_PAD_BYTE;
        end
    end

    assign full_o   = (k_o == KW'(BUS_BYTES));
    // A 2^k-1 pattern has no set bit that survives the carry of +1.
    assign contig_o = ((tkeep_i + BUS_BYTES'(1)) & tkeep_i) == '0;

endmodule

// File: rtl/ascon_rate_padder.sv
// AXI4-Stream padding / rate-alignment stage in front of the Ascon mode FSMs.
// Optional tkeep contiguity check: define ASCON_PADDER_TKEEP_CHECK_EN.
module ascon_rate_padder
    import ascon_pkg::*;
#(
    parameter int BUS_BYTES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  ascon_mode_t            mode_i,
    input  logic [8*BUS_BYTES-1:0] s_axis_tdata,
    input  logic [BUS_BYTES-1:0]   s_axis_tkeep,
    input  axi_tuser_t             s_axis_tuser,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [8*BUS_BYTES-1:0] padded_tdata,
    output logic [BUS_BYTES-1:0]   padded_tkeep,
    output axi_tuser_t             padded_tuser,
    output logic                   padded_tlast,
    output logic                   padded_tblk,
    output logic                   padded_tvalid,
    input  logic                   padded_tready,
    output logic                   err_o
);

    localparam int DW = 8 * BUS_BYTES;
    localparam int KW = $clog2(BUS_BYTES + 1);

    padder_state_t state_q, state_d;
    logic [1:0]    wcnt_q, wcnt_d;
    logic          in_pkt_q, in_pkt_d;
    ascon_mode_t   mode_q, mode_d;
    axi_tuser_t    tuser_q, tuser_d;

    ascon_mode_t   cur_mode;
    axi_tuser_t    cur_user;
    logic          grp_b, blk_end, fire;
    logic [1:0]    wpb_m1;
    logic [DW-1:0] mask_data;
    logic [KW-1:0] pad_k;
    logic          full, contig;

    ascon_pad_mask #(.BUS_BYTES(BUS_BYTES)) u_mask (
        .tdata_i  (s_axis_tdata),
        .tkeep_i  (s_axis_tkeep),
        .data_o   (mask_data),
        .k_o      (pad_k),
        .full_o   (full),
        .contig_o (contig)
    );

    // The first beat of a packet is steered by the live inputs, later beats by the latch.
    always_comb begin
        cur_mode = in_pkt_q ? mode_q  : mode_i;
        cur_user = in_pkt_q ? tuser_q : s_axis_tuser;
        grp_b    = ascon_is_padded(cur_user);
        wpb_m1   = 2'(ascon_rate_bytes(cur_mode) / BUS_BYTES - 1);
        blk_end  = (wcnt_q == wpb_m1);
        fire     = padded_tvalid && padded_tready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= PASS;
            wcnt_q   <= '0;
            in_pkt_q <= 1'b0;
            mode_q   <= MODE_AEAD128;
            tuser_q  <= TU_KEY;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            in_pkt_q <= in_pkt_d;
            mode_q   <= mode_d;
            tuser_q  <= tuser_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        in_pkt_d = in_pkt_q;
        mode_d   = mode_q;
        tuser_d  = tuser_q;
        if (fire) begin
            if (state_q == PASS && !in_pkt_q) begin
                mode_d  = mode_i;
                tuser_d = s_axis_tuser;
            end
            if (grp_b) wcnt_d = blk_end ? 2'd0 : wcnt_q + 2'd1;
            if (padded_tlast) begin
                in_pkt_d = 1'b0;
                wcnt_d   = '0;
            end else begin
                in_pkt_d = 1'b1;
            end
            case (state_q)
                PASS: begin
                    if (grp_b && s_axis_tlast) begin
                        if (full)          state_d = PAD_ONE;
                        else if (!blk_end) state_d = ZERO_FILL;
                    end
                end
                PAD_ONE:   state_d = blk_end ? PASS : ZERO_FILL;
                ZERO_FILL: if (blk_end) state_d = PASS;
                default:   state_d = PASS;
            endcase
        end
    end

    always_comb begin
        s_axis_tready = 1'b0;
        padded_tvalid = 1'b0;
        padded_tdata  = s_axis_tdata;
        padded_tkeep  = '1;
        padded_tuser  = cur_user;
        padded_tlast  = 1'b0;
        padded_tblk   = 1'b0;
        case (state_q)
            PASS: begin
                s_axis_tready = padded_tready && !rst;
                padded_tvalid = s_axis_tvalid && !rst;
                if (!grp_b) begin
                    if (cur_user == TU_CT) padded_tkeep = s_axis_tkeep;
                    padded_tlast = s_axis_tlast;
                end else if (s_axis_tlast) begin
                    padded_tdata = mask_data;
                    padded_tblk  = blk_end;
                    padded_tlast = blk_end && !full;
                end else begin
                    padded_tblk  = blk_end;
                end
            end
            PAD_ONE: begin
                padded_tvalid = !rst;
                padded_tdata  = {{(DW-8){1'b0}}, ASCON_PAD_BYTE};
                padded_tblk   = blk_end;
                padded_tlast  = blk_end;
            end
            ZERO_FILL: begin
                padded_tvalid = !rst;
                padded_tdata  = '0;
                padded_tblk   = blk_end;
                padded_tlast  = blk_end;
            end
            default: ;
        endcase
    end

`ifdef ASCON_PADDER_TKEEP_CHECK_EN
    logic err_q, err_d;
    logic unused_pad_k;

    assign unused_pad_k = ^pad_k;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    always_comb begin
        err_d = err_q;
        if (fire && state_q == PASS && grp_b && s_axis_tlast && !contig) err_d = 1'b1;
    end

    assign err_o = err_q;
`else
    logic unused_sig;

    assign unused_sig = ^{pad_k, contig};
    assign err_o      = 1'b0;
`endif

endmodule
